// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - 2-D window index sequencer: strided column walk with row advance on wrap
module scan_ctrl #(
    parameter int N       = 4,
    parameter int COL_MAX = 9,
    parameter int ROW_MAX = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] col_base,
    input  logic [N-1:0] row_base,
    input  logic [N-1:0] stride,
    input  logic         stall,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] col,
    output logic [N-1:0] row,
    output logic         last,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N:0] COL_LIM = (N+1)'(COL_MAX);
    localparam logic [N:0] ROW_LIM = (N+1)'(ROW_MAX);

    logic [1:0]   state;
    logic [N-1:0] cb_q;
    logic [N-1:0] rb_q;
    logic [N-1:0] stride_q;
    logic         err_q;

    logic [N:0]   nc;
    logic         col_wrap;
    logic         row_end;
    logic         accept;

    // One extra bit so a large stride cannot alias back into the legal range.
    assign nc       = {1'b0, col} + {1'b0, stride_q};
    assign col_wrap = nc > COL_LIM;
    assign row_end  = {1'b0, row} == ROW_LIM;

    assign busy   = state != S_IDLE;
    assign valid  = state == S_SCAN;
    assign accept = valid && !stall;
    assign last   = valid && col_wrap && row_end;
    assign done   = state == S_DONE;
    assign err    = done && err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            col      <= '0;
            row      <= '0;
            cb_q     <= '0;
            rb_q     <= '0;
            stride_q <= N'(1);
            err_q    <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cb_q     <= col_base;
                        rb_q     <= row_base;
                        stride_q <= (stride == '0) ? N'(1) : stride;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    col <= cb_q;
                    row <= rb_q;
                    if (({1'b0, cb_q} > COL_LIM) || ({1'b0, rb_q} > ROW_LIM)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (accept) begin
                        if (!col_wrap) begin
                            col <= nc[N-1:0];
                        end else if (row_end) begin
                            state <= S_DONE;
                        end else begin
                            col <= cb_q;
                            row <= row + N'(1);
                        end
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
